// File: rtl/sat_operand_stage_pkg.sv
// sat_operand_stage_pkg: shared max-channel codes and default widths for the saturation operand stage
package sat_operand_stage_pkg;
  localparam int DW_DEF = 8;
  localparam int CW_DEF = 16;
  localparam logic [1:0] MAX_R = 2'd0;
  localparam logic [1:0] MAX_G = 2'd1;
  localparam logic [1:0] MAX_B = 2'd2;
endpackage

// File: rtl/sat_operand_stage_minmax3.sv
// minmax3: picks max/min of three channels from precomputed compare flags, R>G>B tie priority
module minmax3
  import sat_operand_stage_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] r,
  input  logic [DW-1:0] g,
  input  logic [DW-1:0] b,
  input  logic          ge_rg,
  input  logic          ge_rb,
  input  logic          ge_gb,
  output logic [DW-1:0] mx,
  output logic [DW-1:0] mn,
  output logic [1:0]    idx
);
  always_comb begin
    idx = ge_rg && ge_rb ? MAX_R : ge_gb ? MAX_G : MAX_B;
    mx  = idx == MAX_R ? r : idx == MAX_G ? g : b;
    mn  = ge_rb && ge_gb ? b : ge_rg ? g : r;
  end
endmodule

// File: rtl/sat_operand_stage.sv
// sat_operand_stage: 2-stage RGB -> (max-min, max) divider operand pipeline with per-frame black-pixel count
module sat_operand_stage
  import sat_operand_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_r,
  input  logic [DW-1:0] in_g,
  input  logic [DW-1:0] in_b,
  input  logic          in_sop,
  input  logic          in_eop,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_num,
  output logic [DW-1:0] out_dem,
  output logic [1:0]    out_max_idx,
  output logic          out_zero,
  output logic          out_sop,
  output logic          out_eop,
  output logic [CW-1:0] zcnt,
  output logic          zcnt_valid
);
  logic          s1_valid, s1_ge_rg, s1_ge_rb, s1_ge_gb, s1_sop, s1_eop;
  logic [DW-1:0] s1_r, s1_g, s1_b, mx, mn;
  logic [1:0]    idx;
  logic [CW-1:0] cnt, cnt_base, cnt_next;
  logic          s1_load, s2_load, out_fire;
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign s1_load  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign cnt_base = out_sop ? '0 : cnt;
  assign cnt_next = cnt_base + CW'(out_zero && !(&cnt_base));
  minmax3 #(.DW(DW)) u_minmax3 (
    .r     (s1_r),
    .g     (s1_g),
    .b     (s1_b),
    .ge_rg (s1_ge_rg),
    .ge_rb (s1_ge_rb),
    .ge_gb (s1_ge_gb),
    .mx    (mx),
    .mn    (mn),
    .idx   (idx)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_r        <= '0;
      s1_g        <= '0;
      s1_b        <= '0;
      s1_ge_rg    <= 1'b0;
      s1_ge_rb    <= 1'b0;
      s1_ge_gb    <= 1'b0;
      s1_sop      <= 1'b0;
      s1_eop      <= 1'b0;
      out_valid   <= 1'b0;
      out_num     <= '0;
      out_dem     <= '0;
      out_max_idx <= MAX_R;
      out_zero    <= 1'b0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      cnt         <= '0;
      zcnt        <= '0;
      zcnt_valid  <= 1'b0;
    end else begin
      s1_valid <= s1_load || (s1_valid && !s2_load);
      if (s1_load) begin
        s1_r     <= in_r;
        s1_g     <= in_g;
        s1_b     <= in_b;
        s1_ge_rg <= in_r >= in_g;
        s1_ge_rb <= in_r >= in_b;
        s1_ge_gb <= in_g >= in_b;
        s1_sop   <= in_sop;
        s1_eop   <= in_eop;
      end
      out_valid <= s2_load || (out_valid && !out_ready);
      if (s2_load) begin
        out_num     <= mx - mn;
        out_dem     <= mx;
        out_max_idx <= idx;
        out_zero    <= mx == '0;
        out_sop     <= s1_sop;
        out_eop     <= s1_eop;
      end
      zcnt_valid <= out_fire && out_eop;
      if (out_fire) begin
        cnt <= out_eop ? '0 : cnt_next;
        if (out_eop) zcnt <= cnt_next;
      end
    end
  end
endmodule

// File: tb/tb_sat_operand_stage.sv
// tb_sat_operand_stage: scoreboard bench with directed pixels, backpressure, frame counts and async reset
module tb_sat_operand_stage;
  typedef struct packed {
    logic [7:0] num;
    logic [7:0] dem;
    logic [1:0] idx;
    logic       zero;
    logic       sop;
    logic       eop;
  } beat_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  in_r = '0;
  logic [7:0]  in_g = '0;
  logic [7:0]  in_b = '0;
  logic        in_ready, out_valid, out_zero, out_sop, out_eop, zcnt_valid;
  logic [7:0]  out_num, out_dem;
  logic [1:0]  out_max_idx;
  logic [15:0] zcnt;
  logic        in_ready4, out_valid4, out_zero4, out_sop4, out_eop4, zcnt_valid4;
  logic [7:0]  out_num4, out_dem4;
  logic [1:0]  out_max_idx4;
  logic [3:0]  zcnt4;
  beat_t       exp_q[$];
  logic [15:0] z_q[$];
  logic [3:0]  z4_q[$];
  int          total = 0;
  int          passed = 0;
  int          mode = 0;
  int          pi = 0;
  bit          ir_low = 1'b0;
  logic [5:0]  pat = 6'b101001;
  always #5 clk = ~clk;
  sat_operand_stage #(.DW(8), .CW(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_num(out_num), .out_dem(out_dem),
    .out_max_idx(out_max_idx), .out_zero(out_zero), .out_sop(out_sop), .out_eop(out_eop),
    .zcnt(zcnt), .zcnt_valid(zcnt_valid)
  );
  sat_operand_stage #(.DW(8), .CW(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid4), .out_ready(out_ready), .out_num(out_num4), .out_dem(out_dem4),
    .out_max_idx(out_max_idx4), .out_zero(out_zero4), .out_sop(out_sop4), .out_eop(out_eop4),
    .zcnt(zcnt4), .zcnt_valid(zcnt_valid4)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic sop, input logic eop, input bit chk,
                      input logic [7:0] en, input logic [7:0] ed, input logic [1:0] ei);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_r = r;
    in_g = g;
    in_b = b;
    in_sop = sop;
    in_eop = eop;
    #1;
    while (!in_ready) begin
      ir_low = 1'b1;
      if (++n > 200) begin
        $display("FAIL send_timeout: in_ready stuck at 0");
        $fatal(1);
      end
      @(negedge clk);
      #1;
    end
    if (chk) exp_q.push_back(beat_t'({en, ed, ei, ed == 8'd0, sop, eop}));
    @(posedge clk);
  endtask
  task automatic expect_z(input logic [15:0] z, input logic [3:0] z4);
    z_q.push_back(z);
    z4_q.push_back(z4);
  endtask
  initial forever begin
    @(negedge clk);
    out_ready = mode == 0 ? 1'b1 : mode == 2 ? 1'b0 : pat[pi % 6];
    if (mode == 1) pi++;
  end
  initial begin
    beat_t act, act4, held, e;
    bit stalled = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      act  = {out_num, out_dem, out_max_idx, out_zero, out_sop, out_eop};
      act4 = {out_num4, out_dem4, out_max_idx4, out_zero4, out_sop4, out_eop4};
      if (stalled && out_valid) check("stall_hold", act, held);
      stalled = out_valid && !out_ready;
      held = act;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_out: got %0h expected none", act);
        end else begin
          e = exp_q.pop_front();
          check("payload", act, e);
          check("payload_cw4", {out_valid4, act4}, {1'b1, e});
        end
      end
      if (zcnt_valid) begin
        if (z_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_zcnt: got %0d expected none", zcnt);
        end else check("zcnt", zcnt, z_q.pop_front());
      end
      if (zcnt_valid4) begin
        if (z4_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_zcnt4: got %0d expected none", zcnt4);
        end else check("zcnt_cw4", zcnt4, z4_q.pop_front());
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    #2;
    check("rst_out_valid", {out_valid, out_valid4}, 0);
    check("rst_in_ready", {in_ready, in_ready4}, 2'b11);
    check("rst_zcnt", {zcnt, zcnt4, zcnt_valid, zcnt_valid4}, 0);
    check("rst_payload", {out_num, out_dem, out_max_idx, out_zero, out_sop, out_eop}, 0);
    @(negedge clk);
    rst = 1'b0;
    send(200, 100, 50, 0, 0, 1, 150, 200, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    check("latency_1", out_valid, 0);
    @(negedge clk);
    #2;
    check("latency_2", out_valid, 1);
    send(80, 80, 80, 0, 0, 1, 0, 80, 0);
    send(10, 90, 90, 0, 0, 1, 80, 90, 1);
    send(0, 0, 255, 0, 0, 1, 255, 255, 2);
    send(90, 10, 90, 0, 0, 1, 80, 90, 0);
    expect_z(2, 2);
    send(10, 20, 30, 1, 0, 1, 20, 30, 2);
    send(0, 0, 0, 0, 0, 1, 0, 0, 0);
    send(5, 5, 6, 0, 0, 1, 1, 6, 2);
    send(0, 0, 0, 0, 0, 1, 0, 0, 0);
    send(7, 3, 7, 0, 1, 1, 4, 7, 0);
    expect_z(0, 0);
    send(1, 2, 3, 1, 0, 1, 2, 3, 2);
    send(9, 8, 7, 0, 0, 1, 2, 9, 0);
    send(4, 4, 9, 0, 1, 1, 5, 9, 2);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    ir_low = 1'b0;
    mode = 1;
    send(1, 2, 3, 0, 0, 1, 2, 3, 2);
    send(250, 5, 100, 0, 0, 1, 245, 250, 0);
    send(7, 9, 8, 0, 0, 1, 2, 9, 1);
    send(0, 1, 0, 0, 0, 1, 1, 1, 1);
    send(128, 128, 127, 0, 0, 1, 1, 128, 0);
    send(33, 44, 255, 0, 0, 1, 222, 255, 2);
    check("bp_in_ready_low", ir_low, 1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    mode = 0;
    expect_z(20, 15);
    for (int i = 0; i < 20; i++) send(0, 0, 0, i == 0, i == 19, 1, 0, 0, 0);
    expect_z(1, 1);
    send(0, 0, 0, 1, 1, 1, 0, 0, 0);
    expect_z(0, 0);
    send(0, 0, 0, 1, 0, 1, 0, 0, 0);
    send(0, 0, 0, 0, 0, 1, 0, 0, 0);
    send(1, 1, 1, 1, 1, 1, 0, 1, 0);
    send(0, 0, 0, 1, 0, 1, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    mode = 2;
    send(50, 50, 50, 0, 0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    check("full_out_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", {out_valid, out_valid4}, 0);
    check("async_rst_zcnt", {zcnt, zcnt4, zcnt_valid}, 0);
    check("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    mode = 0;
    expect_z(0, 0);
    send(30, 60, 90, 0, 1, 1, 60, 90, 2);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 100 && (exp_q.size() + z_q.size() + z4_q.size()) > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("drain", exp_q.size() + z_q.size() + z4_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
